// File: rtl/hex_word_ascii_streamer_pkg.sv
// Shared ASCII constants, state encoding and nibble helpers for the hex word printer.
// Pure declarations; no latency or flow control of its own.
package hex_word_ascii_streamer_pkg;

    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_A_UC = 8'h41;
    localparam logic [7:0] ASCII_A_LC = 8'h61;
    localparam logic [7:0] ASCII_X    = 8'h78;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PFX0  = 3'd1;
    localparam logic [2:0] ST_PFXX  = 3'd2;
    localparam logic [2:0] ST_DIGIT = 3'd3;
    localparam logic [2:0] ST_CR    = 3'd4;
    localparam logic [2:0] ST_LF    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_PFX0  = ST_PFX0,
        S_PFXX  = ST_PFXX,
        S_DIGIT = ST_DIGIT,
        S_CR    = ST_CR,
        S_LF    = ST_LF
    } state_e;

    function automatic logic [3:0] get_nib(input logic [63:0] w, input logic [3:0] idx);
        return w[{idx, 2'b00} +: 4];
    endfunction

    // Index of the most significant non-zero nibble; 0 for an all-zero word.
    function automatic logic [3:0] first_nz(input logic [63:0] w);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w[4*i +: 4] != 4'h0) r = 4'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/hex_word_ascii_streamer_nibble_ascii_enc.sv
// Nibble to ASCII hex digit encoder; purely combinational.
// No latency, no flow control.
module nibble_ascii_enc
    import hex_word_ascii_streamer_pkg::*;
#(
    parameter int LOWERCASE = 0
) (
    input  logic [3:0] nib_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        if (nib_i < 4'd10) ascii_o = ASCII_0 + {4'h0, nib_i};
        else ascii_o = ((LOWERCASE != 0) ? ASCII_A_LC : ASCII_A_UC) + {4'h0, nib_i - 4'd10};
    end

endmodule

// File: rtl/hex_word_ascii_streamer.sv
// Streams a word as hex ASCII, MSB nibble first; first char 1 cycle after accept, then one per handshake.
// Backpressure: character held stable while OUT_READY is low; IN_READY only when idle.
module hex_word_ascii_streamer
    import hex_word_ascii_streamer_pkg::*;
#(
    parameter int NIBBLES     = 4,
    parameter int LOWERCASE   = 0,
    parameter int PREFIX_0X   = 0,
    parameter int SUPPRESS_LZ = 0,
    parameter int APPEND_CRLF = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [4*NIBBLES-1:0]   IN_DATA,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    output logic [7:0]             OUT_ASCII,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic                   BUSY
);

    state_e               state_q, state_d;
    logic [4*NIBBLES-1:0] word_q, word_d;
    logic [3:0]           idx_q, idx_d;
    logic [7:0]           ascii_q, ascii_d;
    logic                 out_vld_q, out_vld_d;
    logic                 in_rdy_q, in_rdy_d;
    logic                 busy_q, busy_d;

    logic [3:0] start_idx;
    logic [3:0] enc_nib;
    logic [7:0] enc_ascii;
    logic       out_hs;

    assign out_hs    = out_vld_q & OUT_READY;
    assign start_idx = (SUPPRESS_LZ != 0) ? first_nz(64'(IN_DATA)) : 4'(NIBBLES - 1);

    // The encoder always sees the nibble of the character that would be loaded next.
    always_comb begin
        enc_nib = get_nib(64'(word_q), idx_q);
        if (state_q == S_IDLE) enc_nib = get_nib(64'(IN_DATA), start_idx);
        else if (state_q == S_DIGIT) enc_nib = get_nib(64'(word_q), idx_q - 4'd1);
    end

    nibble_ascii_enc #(.LOWERCASE(LOWERCASE)) u_enc (
        .nib_i   (enc_nib),
        .ascii_o (enc_ascii)
    );

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        idx_d     = idx_q;
        ascii_d   = ascii_q;
        out_vld_d = out_vld_q;
        in_rdy_d  = in_rdy_q;
        busy_d    = busy_q;
        case (state_q)
            S_IDLE: begin
                if (IN_VALID) begin
                    word_d    = IN_DATA;
                    idx_d     = start_idx;
                    out_vld_d = 1'b1;
                    busy_d    = 1'b1;
                    in_rdy_d  = 1'b0;
                    if (PREFIX_0X != 0) begin
                        state_d = S_PFX0;
                        ascii_d = ASCII_0;
                    end else begin
                        state_d = S_DIGIT;
                        ascii_d = enc_ascii;
                    end
                end
            end
            S_PFX0: if (out_hs) begin
                state_d = S_PFXX;
                ascii_d = ASCII_X;
            end
            S_PFXX: if (out_hs) begin
                state_d = S_DIGIT;
                ascii_d = enc_ascii;
            end
            S_DIGIT: if (out_hs) begin
                if (idx_q != 4'd0) begin
                    idx_d   = idx_q - 4'd1;
                    ascii_d = enc_ascii;
                end else if (APPEND_CRLF != 0) begin
                    state_d = S_CR;
                    ascii_d = ASCII_CR;
                end else begin
                    state_d   = S_IDLE;
                    ascii_d   = 8'h00;
                    out_vld_d = 1'b0;
                    busy_d    = 1'b0;
                    in_rdy_d  = 1'b1;
                end
            end
            S_CR: if (out_hs) begin
                state_d = S_LF;
                ascii_d = ASCII_LF;
            end
            S_LF: if (out_hs) begin
                state_d   = S_IDLE;
                ascii_d   = 8'h00;
                out_vld_d = 1'b0;
                busy_d    = 1'b0;
                in_rdy_d  = 1'b1;
            end
            default: begin
                state_d   = S_IDLE;
                ascii_d   = 8'h00;
                out_vld_d = 1'b0;
                busy_d    = 1'b0;
                in_rdy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            word_q    <= '0;
            idx_q     <= 4'd0;
            ascii_q   <= 8'h00;
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            idx_q     <= idx_d;
            ascii_q   <= ascii_d;
            out_vld_q <= out_vld_d;
            in_rdy_q  <= in_rdy_d;
            busy_q    <= busy_d;
        end
    end

    assign IN_READY  = in_rdy_q;
    assign OUT_ASCII = ascii_q;
    assign OUT_VALID = out_vld_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_hex_word_ascii_streamer.sv
// Directed bench: four parameter variants, expected characters queued at stimulus time and popped on each output handshake.
module tb_hex_word_ascii_streamer;

    typedef struct {
        int         inst;
        logic [7:0] ch;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        out_rdy;
    logic        in_vld  [4];
    logic        in_rdy  [4];
    logic [7:0]  ascii   [4];
    logic        vld     [4];
    logic        busy    [4];

    exp_t        exp_q[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic        held    [4];
    logic [7:0]  held_ch [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hex_word_ascii_streamer u_a (
        .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_vld[0]), .IN_READY(in_rdy[0]),
        .OUT_ASCII(ascii[0]), .OUT_VALID(vld[0]), .OUT_READY(out_rdy), .BUSY(busy[0])
    );

    hex_word_ascii_streamer #(.LOWERCASE(1), .PREFIX_0X(1), .APPEND_CRLF(0)) u_b (
        .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_vld[1]), .IN_READY(in_rdy[1]),
        .OUT_ASCII(ascii[1]), .OUT_VALID(vld[1]), .OUT_READY(out_rdy), .BUSY(busy[1])
    );

    hex_word_ascii_streamer #(.SUPPRESS_LZ(1)) u_c (
        .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_vld[2]), .IN_READY(in_rdy[2]),
        .OUT_ASCII(ascii[2]), .OUT_VALID(vld[2]), .OUT_READY(out_rdy), .BUSY(busy[2])
    );

    hex_word_ascii_streamer #(.NIBBLES(1), .SUPPRESS_LZ(1)) u_d (
        .CLK(clk), .RST(rst), .IN_DATA(in_data[3:0]), .IN_VALID(in_vld[3]), .IN_READY(in_rdy[3]),
        .OUT_ASCII(ascii[3]), .OUT_VALID(vld[3]), .OUT_READY(out_rdy), .BUSY(busy[3])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [7:0] c);
        exp_t e;
        e.inst = k;
        e.ch   = c;
        exp_q.push_back(e);
    endtask

    task automatic push_hex4(input int k, input logic [15:0] w);
        logic [3:0] n;
        for (int i = 3; i >= 0; i--) begin
            n = w[4*i +: 4];
            push(k, (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10));
        end
        push(k, 8'h0D);
        push(k, 8'h0A);
    endtask

    task automatic accept(input int k, input logic [15:0] d);
        in_data   = d;
        in_vld[k] = 1'b1;
        tick();
        in_vld[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || vld[k]) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk("drain_idle_rdy", 32'(in_rdy[k]), 32'd1);
    endtask

    // Handshake monitor: pops the scoreboard on every accepted character and checks hold stability.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) held[k] = 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (held[k] && vld[k]) chk("hold_stable", 32'(ascii[k]), 32'(held_ch[k]));
                if (vld[k] && out_rdy) begin
                    chk("unexpected_char", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("char_inst", 32'(k), 32'(e.inst));
                        chk("char_val", 32'(ascii[k]), 32'(e.ch));
                    end
                end
                held[k]    = vld[k] && !out_rdy;
                held_ch[k] = ascii[k];
            end
        end
    end

    initial begin
        int n;
        rst     = 1'b1;
        in_data = 16'h0;
        out_rdy = 1'b1;
        for (int k = 0; k < 4; k++) in_vld[k] = 1'b0;
        repeat (2) tick();
        chk("rst_in_ready", 32'(in_rdy[0]), 32'd1);
        chk("rst_out_valid", 32'(vld[0]), 32'd0);
        chk("rst_ascii", 32'(ascii[0]), 32'h00);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        rst = 1'b0;
        tick();

        // A3F0 at full rate: six back-to-back characters, one cycle after accept.
        push_hex4(0, 16'hA3F0);
        accept(0, 16'hA3F0);
        chk("lat_busy", 32'(busy[0]), 32'd1);
        chk("lat_in_ready", 32'(in_rdy[0]), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("no_bubble", 32'(vld[0]), 32'd1);
            tick();
        end
        chk("done_valid", 32'(vld[0]), 32'd0);
        chk("done_in_ready", 32'(in_rdy[0]), 32'd1);
        chk("done_busy", 32'(busy[0]), 32'd0);
        tick();

        // Lowercase, 0x prefix, no CRLF.
        push(1, 8'h30); push(1, 8'h78); push(1, 8'h30);
        push(1, 8'h30); push(1, 8'h62); push(1, 8'h65);
        accept(1, 16'h00BE);
        drain(1);

        // Leading-zero suppression.
        push(2, 8'h30); push(2, 8'h0D); push(2, 8'h0A);
        accept(2, 16'h0000);
        drain(2);
        tick();
        push(2, 8'h43); push(2, 8'h0D); push(2, 8'h0A);
        accept(2, 16'h000C);
        drain(2);
        tick();
        push(3, 8'h30); push(3, 8'h0D); push(3, 8'h0A);
        accept(3, 16'h0000);
        drain(3);
        tick();

        // Back-pressure with random hold lengths.
        push_hex4(0, 16'h1234);
        accept(0, 16'h1234);
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            out_rdy = 1'b0;
            repeat ($urandom_range(0, 5)) begin
                tick();
                n++;
            end
            out_rdy = 1'b1;
            tick();
            n++;
        end
        out_rdy = 1'b1;
        drain(0);
        tick();

        // IN_VALID held high with new data mid-stream.
        push_hex4(0, 16'h1111);
        push_hex4(0, 16'hFFFF);
        in_data   = 16'h1111;
        in_vld[0] = 1'b1;
        tick();
        in_data = 16'hFFFF;
        repeat (6) tick();
        chk("gap_valid", 32'(vld[0]), 32'd0);
        chk("gap_in_ready", 32'(in_rdy[0]), 32'd1);
        tick();
        in_vld[0] = 1'b0;
        chk("next_valid", 32'(vld[0]), 32'd1);
        chk("next_first", 32'(ascii[0]), 32'h46);
        drain(0);
        tick();

        // Asynchronous reset after the second character.
        push(0, 8'h35); push(0, 8'h36);
        accept(0, 16'h5678);
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(vld[0]), 32'd0);
        chk("arst_in_ready", 32'(in_rdy[0]), 32'd1);
        chk("arst_busy", 32'(busy[0]), 32'd0);
        chk("arst_ascii", 32'(ascii[0]), 32'h00);
        chk("arst_pending", 32'(exp_q.size()), 32'd0);
        #3 rst = 1'b0;
        tick();
        repeat (3) tick();
        push_hex4(0, 16'h9ABC);
        accept(0, 16'h9ABC);
        chk("post_rst_first", 32'(ascii[0]), 32'h39);
        drain(0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
